uni_to_bi: RTL and testbench

//  Converts a unipolar stochastic bitstream (value u = P(in=1), 0..1) into a bipolar bitstream

---
 rtl/sc_stream_pkg.sv | 39 +++
 rtl/uni_to_bi_if.sv | 40 ++++
 rtl/bitstream_frame_cnt.sv | 59 +++++
 rtl/uni_to_bi.sv | 97 +++++++++
 tb/tb_uni_to_bi.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sc_stream_pkg.sv
// Shared definitions for the stochastic-computing stream blocks: accumulator
// midpoint, frame-count sizing and the per-cycle input classification.
package sc_stream_pkg;

    localparam int DEFAULT_DEP = 3;
    localparam int DEFAULT_LEN = 256;

    // Resting value of a DEP-bit converter accumulator.
    function automatic int acc_mid(input int dep);
        return 1 << (dep - 1);
    endfunction

    // Width that holds a ones count from 0 to len inclusive.
    function automatic int frame_cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Frame-count type for the default frame length.
    typedef logic [$clog2(DEFAULT_LEN + 1)-1:0] frame_cnt_t;

    // What the stream logic does in a given (non-reset) cycle.
    typedef enum logic [1:0] {
        CYC_IDLE   = 2'd0,
        CYC_ACCEPT = 2'd1,
        CYC_CLEAR  = 2'd2
    } cyc_kind_e;

    // Clear wins over a valid input bit; the bit is simply dropped.
    function automatic cyc_kind_e cyc_kind(input logic clear, input logic in_valid);
        if (clear) begin
            return CYC_CLEAR;
        end
        if (in_valid) begin
            return CYC_ACCEPT;
        end
        return CYC_IDLE;
    endfunction

endpackage

// File: rtl/uni_to_bi_if.sv
// Stream interface of the unipolar-to-bipolar converter: control and input bit
// from the producer, converted bit plus frame bookkeeping back.
interface uni_to_bi_if
    import sc_stream_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
);
    localparam int CNT_W = frame_cnt_w(LEN);

    logic             clear;
    logic             in_valid;
    logic             in;
    logic             out_valid;
    logic             out;
    logic             frame_done;
    logic [CNT_W-1:0] ones_total;

    // Producer / scoreboard side.
    modport master (
        output clear,
        output in_valid,
        output in,
        input  out_valid,
        input  out,
        input  frame_done,
        input  ones_total
    );

    // Converter side.
    modport slave (
        input  clear,
        input  in_valid,
        input  in,
        output out_valid,
        output out,
        output frame_done,
        output ones_total
    );

endinterface

// File: rtl/bitstream_frame_cnt.sv
// Frame bookkeeping for a bitstream: counts accepted bits into LEN-bit frames,
// accumulates the ones in the running frame and publishes the total when the
// frame's last bit is accepted.
module bitstream_frame_cnt
    import sc_stream_pkg::*;
#(
    parameter  int LEN   = DEFAULT_LEN,
    localparam int CNT_W = frame_cnt_w(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             sbit,
    output logic             last,
    output logic             frame_done,
    output logic [CNT_W-1:0] ones_total
);

    localparam int IDX_W = $clog2(LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    logic [IDX_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ones_run;

    // The bit being accepted now closes the frame.
    assign last = (cyc_cnt == IDX_LAST);

    // Frame position, running ones count and the published total.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt    <= '0;
            ones_run   <= '0;
            frame_done <= 1'b0;
            ones_total <= '0;
        end else if (clear) begin
            // Abort the running frame; the last published total stays valid.
            cyc_cnt    <= '0;
            ones_run   <= '0;
            frame_done <= 1'b0;
        end else if (inc) begin
            if (last) begin
                frame_done <= 1'b1;
                ones_total <= ones_run + CNT_W'(sbit);
                ones_run   <= '0;
                cyc_cnt    <= '0;
            end else begin
                frame_done <= 1'b0;
                ones_run   <= ones_run + CNT_W'(sbit);
                cyc_cnt    <= cyc_cnt + IDX_W'(1);
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/uni_to_bi.sv
// Unipolar-to-bipolar stochastic bitstream converter. A small accumulator
// balances input ones against emitted ones so that P(out=1) = (u+1)/2,
// without any random source. Frames of LEN accepted bits are counted for
// scoreboarding and each frame restarts the accumulator at its midpoint.
// DEP must be at least 3 and LEN at least 2; the interface must be built with
// the same LEN as this module.
module uni_to_bi
    import sc_stream_pkg::*;
#(
    parameter int DEP = DEFAULT_DEP,
    parameter int LEN = DEFAULT_LEN
) (
    input  logic          clk,
    input  logic          rst,
    uni_to_bi_if.slave    bus
);

    localparam int CNT_W = frame_cnt_w(LEN);
    localparam logic [DEP-1:0] ACC_MID = DEP'(acc_mid(DEP));

    // Accumulator only ever holds MID, MID+1 or MID+2.
    logic [DEP-1:0]   acc;
    logic [DEP-1:0]   acc_next;
    logic [DEP:0]     acc_sum;
    logic             dec;
    logic             last;
    logic             accept;
    cyc_kind_e        kind;

    logic             out_valid_q;
    logic             out_q;
    logic             frame_done;
    logic [CNT_W-1:0] ones_total;

    // Emit a one whenever the accumulator sits above its midpoint.
    assign dec    = (acc > ACC_MID);
    assign accept = (kind == CYC_ACCEPT);

    // Cycle classification and accumulator update for an accepted bit.
    // NOTE: every signal driven here is assigned on every path through the
    // block, so it stays purely combinational and no latch is inferred.
    always_comb begin
        kind     = cyc_kind(bus.clear, bus.in_valid);
        acc_sum  = {1'b0, acc}
                 + (DEP+1)'(bus.in)
                 + (DEP+1)'(1)
                 - (DEP+1)'({dec, 1'b0});
        // A carry out of DEP bits cannot occur from a legal state; treat it
        // like a frame boundary so the accumulator can never wander off.
        acc_next = (last || acc_sum[DEP]) ? ACC_MID : acc_sum[DEP-1:0];
    end

    // Accumulator and registered output bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= ACC_MID;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            case (kind)
                CYC_CLEAR: begin
                    acc         <= ACC_MID;
                    out_valid_q <= 1'b0;
                    out_q       <= 1'b0;
                end
                CYC_ACCEPT: begin
                    acc         <= acc_next;
                    out_valid_q <= 1'b1;
                    out_q       <= dec;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_q       <= 1'b0;
                end
            endcase
        end
    end

    bitstream_frame_cnt #(
        .LEN (LEN)
    ) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (bus.clear),
        .inc        (accept),
        .sbit       (dec),
        .last       (last),
        .frame_done (frame_done),
        .ones_total (ones_total)
    );

    assign bus.out_valid  = out_valid_q;
    assign bus.out        = out_q;
    assign bus.frame_done = frame_done;
    assign bus.ones_total = ones_total;

endmodule

// File: tb/tb_uni_to_bi.sv
// Directed bench for uni_to_bi: DEP=3/LEN=16 hand-computed streams, clear and
// reset mid-frame, plus a DEP=5/LEN=64 stream at p=0.25 checked against the
// expected ones count.
module tb_uni_to_bi;
    import sc_stream_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uni_to_bi_if #(.LEN(16)) b3 ();
    uni_to_bi_if #(.LEN(64)) b5 ();

    uni_to_bi #(.DEP(3), .LEN(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    uni_to_bi #(.DEP(5), .LEN(64)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive the small instance for one cycle; called at a negedge, returns at
    // the next negedge so outputs registered in between can be sampled.
    task automatic step3(input logic v, input logic b, input logic clr);
        b3.in_valid = v;
        b3.in       = b;
        b3.clear    = clr;
        @(negedge clk);
    endtask

    task automatic check_idle3(input string tag, input int exp_total);
        check({tag, "_valid"}, b3.out_valid, 0);
        check({tag, "_out"}, b3.out, 0);
        check({tag, "_done"}, b3.frame_done, 0);
        check({tag, "_total"}, b3.ones_total, exp_total);
    endtask

    // One 16-bit frame; optional run of idle cycles before accepted bit gap_at.
    task automatic run_frame(input string tag, input logic [15:0] din,
                             input logic [15:0] exp_out, input int gap_at,
                             input int gap_len, input int prev_total,
                             input int exp_total);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step3(1'b0, 1'b1, 1'b0);
                    check_idle3({tag, "_gap"}, prev_total);
                end
            end
            step3(1'b1, din[i], 1'b0);
            check({tag, "_valid"}, b3.out_valid, 1);
            check({tag, "_out"}, b3.out, exp_out[i]);
            check({tag, "_done"}, b3.frame_done, (i == 15) ? 1 : 0);
            if (i < 15) begin
                check({tag, "_total_held"}, b3.ones_total, prev_total);
            end
        end
        check({tag, "_total"}, b3.ones_total, exp_total);
        step3(1'b0, 1'b0, 1'b0);
        check_idle3({tag, "_after"}, exp_total);
    endtask

    // DEP=5, LEN=64: exactly 16 ones placed at random positions (p=0.25).
    task automatic run_dep5();
        logic [63:0] pat;
        int placed;
        int k;
        int dones;
        int tot;
        pat    = '0;
        placed = 0;
        while (placed < 16) begin
            k = $urandom_range(63, 0);
            if (!pat[k]) begin
                pat[k] = 1'b1;
                placed++;
            end
        end
        dones = 0;
        for (int i = 0; i < 64; i++) begin
            b5.in_valid = 1'b1;
            b5.in       = pat[i];
            @(negedge clk);
            if (b5.frame_done) begin
                dones++;
            end
        end
        b5.in_valid = 1'b0;
        b5.in       = 1'b0;
        check("t7_valid_last", b5.out_valid, 1);
        check("t7_done_last", b5.frame_done, 1);
        check("t7_done_count", dones, 1);
        tot = int'(b5.ones_total);
        check("t7_total_near_40", (tot >= 39 && tot <= 41) ? 1 : 0, 1);
        @(negedge clk);
        check("t7_done_pulse", b5.frame_done, 0);
        check("t7_total_held", b5.ones_total, tot);
    endtask

    initial begin
        rst         = 1'b1;
        b3.clear    = 1'b0;
        b3.in_valid = 1'b0;
        b3.in       = 1'b0;
        b5.clear    = 1'b0;
        b5.in_valid = 1'b0;
        b5.in       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle3("reset", 0);
        check("reset_dep5_valid", b5.out_valid, 0);
        check("reset_dep5_total", b5.ones_total, 0);
        rst = 1'b0;

        // 1: all zeros -> alternating 0,1; total 8.
        run_frame("t1", 16'h0000, 16'hAAAA, -1, 0, 0, 8);
        // 2: all ones -> 0 then ones; total 15.
        run_frame("t2", 16'hFFFF, 16'hFFFE, -1, 0, 8, 15);
        // 3: 1,0,1,0,... -> 0,1,1,1 repeating; total 12.
        run_frame("t3", 16'h5555, 16'hEEEE, -1, 0, 15, 12);
        // 4: test 1 with cycles 3-5 idle; same accepted-bit output.
        run_frame("t4", 16'h0000, 16'hAAAA, 2, 3, 12, 8);

        // 5: fresh reset, 7 bits of test 2, clear (with a dropped bit), then zeros.
        rst = 1'b1;
        step3(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_idle3("t5_reset", 0);
        for (int i = 0; i < 7; i++) begin
            step3(1'b1, 1'b1, 1'b0);
            check("t5_pre_out", b3.out, (i == 0) ? 0 : 1);
            check("t5_pre_done", b3.frame_done, 0);
        end
        step3(1'b1, 1'b1, 1'b1);
        check_idle3("t5_clear", 0);
        run_frame("t5", 16'h0000, 16'hAAAA, -1, 0, 0, 8);

        // 6: reset mid-frame for one cycle, then test 3 again.
        for (int i = 0; i < 5; i++) begin
            step3(1'b1, 1'b1, 1'b0);
        end
        rst = 1'b1;
        step3(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check_idle3("t6_reset", 0);
        run_frame("t6", 16'h5555, 16'hEEEE, -1, 0, 0, 12);

        // 7: larger configuration.
        run_dep5();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
